// File: rtl/aes_out_serializer_if.sv
// Bundles the block input stream and the word output stream of the AES output serializer.
//   blk_valid / blk_data : one 128-bit result per high cycle, no back-pressure
//   word_valid / word_ready / word_data / word_last : 32-bit valid/ready word stream
// Modport slave is the serializer itself; master is the environment that drives it.
interface aes_out_serializer_if;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         word_ready;
    logic         word_valid;
    logic [31:0]  word_data;
    logic         word_last;

    modport slave (
        input  blk_valid,
        input  blk_data,
        input  word_ready,
        output word_valid,
        output word_data,
        output word_last
    );

    modport master (
        output blk_valid,
        output blk_data,
        output word_ready,
        input  word_valid,
        input  word_data,
        input  word_last
    );
endinterface

// File: rtl/aes_out_serializer.sv
// AES output serializer: buffers 128-bit AES results in a DEPTH-block circular FIFO and drains
// each block as four 32-bit words, most significant word first.
// Ports:
//   AES_clk, AES_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : block input stream and word output stream
//   fifo_level         : blocks stored, including the one being drained
//   overflow           : sticky flag, a block arrived while full with no pop
//   ovf_clr            : synchronous clear of overflow (a new drop in the same cycle wins)
module aes_out_serializer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic               AES_clk,
    input  logic               AES_rst_n,
    aes_out_serializer_if.slave bus,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               overflow,
    input  logic               ovf_clr
);

    localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FullCnt = LVL_W'(DEPTH);

    logic [127:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic [1:0]       r_idx;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_xfer;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [127:0]     w_head;
    logic [31:0]      w_word;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FullCnt);
    assign w_xfer  = ~w_empty & bus.word_ready;
    assign w_pop   = w_xfer & (r_idx == 2'd3);
    // A full FIFO still accepts a block when the head retires in the same cycle.
    assign w_push  = bus.blk_valid & (~w_full | w_pop);
    assign w_drop  = bus.blk_valid & w_full & ~w_pop;

    // Block storage needs no reset: word_data is forced to zero while empty.
    always_ff @(posedge AES_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.blk_data;
        end
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_idx      <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // idx wraps 3 -> 0 on its own, which coincides with the pop.
            if (w_xfer) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_word = 32'd0;
        unique case (r_idx)
            2'd0: w_word = w_head[127:96];
            2'd1: w_word = w_head[95:64];
            2'd2: w_word = w_head[63:32];
            2'd3: w_word = w_head[31:0];
        endcase
    end

    // Outputs depend only on registered state, never on word_ready or blk_*.
    assign bus.word_valid = ~w_empty;
    assign bus.word_data  = w_empty ? 32'd0 : w_word;
    assign bus.word_last  = ~w_empty & (r_idx == 2'd3);
    assign fifo_level     = r_count;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer (DEPTH = 2): single block, back-pressure, overflow,
// push-while-full-with-pop, asynchronous reset mid-block and set/clear collision.
module tb_aes_out_serializer;

    localparam logic [127:0] K = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] A = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B = 128'h10203040_50607080_90a0b0c0_d0e0f000;
    localparam logic [127:0] C = 128'hdeadbeef_cafef00d_01020304_a5a5a5a5;

    logic       clk;
    logic       rst_n;
    logic [1:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0]  q_words [$];
    logic         q_last  [$];
    int           q_cyc   [$];
    logic [127:0] exp_blks [$];

    aes_out_serializer_if bus ();

    aes_out_serializer #(
        .DEPTH (2)
    ) dut (
        .AES_clk    (clk),
        .AES_rst_n  (rst_n),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every word transfer; inputs change only 1 ns after the rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.word_valid && bus.word_ready) begin
            q_words.push_back(bus.word_data);
            q_last.push_back(bus.word_last);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_words.delete();
        q_last.delete();
        q_cyc.delete();
        exp_blks.delete();
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] blk, input int i);
        logic [127:0] b;
        b = blk;
        return b[127 - 32 * i -: 32];
    endfunction

    task automatic check_stream(input string tag);
        int n;
        n = exp_blks.size() * 4;
        check_eq({tag, " count"}, 128'(q_words.size()), 128'(n));
        for (int i = 0; i < n && i < q_words.size(); i++) begin
            check_eq($sformatf("%s w%0d", tag, i), 128'(q_words[i]),
                     128'(word_of(exp_blks[i / 4], i % 4)));
            check_eq($sformatf("%s last%0d", tag, i), 128'(q_last[i]), 128'((i % 4) == 3));
        end
    endtask

    initial begin
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n          = 1'b0;
        ovf_clr        = 1'b0;
        bus.blk_valid  = 1'b0;
        bus.blk_data   = '0;
        bus.word_ready = 1'b0;
        #1;
        check_eq("rst valid", 128'(bus.word_valid), 128'd0);
        check_eq("rst data", 128'(bus.word_data), 128'd0);
        check_eq("rst last", 128'(bus.word_last), 128'd0);
        check_eq("rst level", 128'(fifo_level), 128'd0);
        check_eq("rst ovf", 128'(overflow), 128'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single block at full rate.
        clear_log();
        bus.blk_valid  = 1'b1;
        bus.blk_data   = K;
        bus.word_ready = 1'b1;
        step();
        bus.blk_valid = 1'b0;
        check_eq("t1 valid", 128'(bus.word_valid), 128'd1);
        check_eq("t1 w0", 128'(bus.word_data), 128'h01234567);
        check_eq("t1 last0", 128'(bus.word_last), 128'd0);
        check_eq("t1 level", 128'(fifo_level), 128'd1);
        step();
        check_eq("t1 w1", 128'(bus.word_data), 128'h89abcdef);
        step();
        check_eq("t1 w2", 128'(bus.word_data), 128'hfedcba98);
        step();
        check_eq("t1 w3", 128'(bus.word_data), 128'h76543210);
        check_eq("t1 last3", 128'(bus.word_last), 128'd1);
        step();
        check_eq("t1 idle valid", 128'(bus.word_valid), 128'd0);
        check_eq("t1 idle data", 128'(bus.word_data), 128'd0);
        check_eq("t1 idle level", 128'(fifo_level), 128'd0);
        check_eq("t1 xfers", 128'(q_words.size()), 128'd4);

        // Back-pressure: hold, then ready pattern 1,0,1,1,1.
        clear_log();
        bus.word_ready = 1'b0;
        bus.blk_valid  = 1'b1;
        bus.blk_data   = K;
        step();
        bus.blk_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t2 hold%0d", i), 128'(bus.word_data), 128'h01234567);
            check_eq($sformatf("t2 hold last%0d", i), 128'(bus.word_last), 128'd0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            bus.word_ready = pat[i];
            step();
        end
        bus.word_ready = 1'b0;
        exp_blks.push_back(K);
        check_stream("t2");
        check_eq("t2 level", 128'(fifo_level), 128'd0);

        // Overflow: A, B, C while stalled; C is dropped.
        clear_log();
        bus.blk_valid = 1'b1;
        bus.blk_data  = A;
        step();
        bus.blk_data = B;
        step();
        bus.blk_data = C;
        step();
        bus.blk_valid = 1'b0;
        check_eq("t3 level", 128'(fifo_level), 128'd2);
        check_eq("t3 ovf", 128'(overflow), 128'd1);
        bus.word_ready = 1'b1;
        repeat (10) step();
        bus.word_ready = 1'b0;
        exp_blks.push_back(A);
        exp_blks.push_back(B);
        check_stream("t3");
        check_eq("t3 drained", 128'(fifo_level), 128'd0);
        check_eq("t3 ovf sticky", 128'(overflow), 128'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_eq("t3 ovf clr", 128'(overflow), 128'd0);

        // Push while full, landing on the cycle A's last word transfers.
        clear_log();
        bus.blk_valid = 1'b1;
        bus.blk_data  = A;
        step();
        bus.blk_data = B;
        step();
        bus.blk_valid = 1'b0;
        check_eq("t4 full", 128'(fifo_level), 128'd2);
        bus.word_ready = 1'b1;
        repeat (3) step();
        check_eq("t4 at w3", 128'(bus.word_last), 128'd1);
        bus.blk_valid = 1'b1;
        bus.blk_data  = C;
        step();
        bus.blk_valid = 1'b0;
        check_eq("t4 level", 128'(fifo_level), 128'd2);
        check_eq("t4 ovf", 128'(overflow), 128'd0);
        repeat (10) step();
        bus.word_ready = 1'b0;
        exp_blks.push_back(A);
        exp_blks.push_back(B);
        exp_blks.push_back(C);
        check_stream("t4");
        if (q_cyc.size() == 12) begin
            check_eq("t4 span", 128'(q_cyc[11] - q_cyc[0]), 128'd11);
        end else begin
            check_eq("t4 span n", 128'(q_cyc.size()), 128'd12);
        end
        check_eq("t4 drained", 128'(fifo_level), 128'd0);

        // Asynchronous reset after two words of A.
        clear_log();
        bus.blk_valid = 1'b1;
        bus.blk_data  = A;
        step();
        bus.blk_valid  = 1'b0;
        bus.word_ready = 1'b1;
        step();
        step();
        bus.word_ready = 1'b0;
        check_eq("t5 xfers", 128'(q_words.size()), 128'd2);
        check_eq("t5 pre w2", 128'(bus.word_data), 128'h8899aabb);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t5 rst valid", 128'(bus.word_valid), 128'd0);
        check_eq("t5 rst data", 128'(bus.word_data), 128'd0);
        check_eq("t5 rst last", 128'(bus.word_last), 128'd0);
        check_eq("t5 rst level", 128'(fifo_level), 128'd0);
        step();
        rst_n         = 1'b1;
        bus.blk_valid = 1'b1;
        bus.blk_data  = B;
        step();
        bus.blk_valid = 1'b0;
        check_eq("t5 B valid", 128'(bus.word_valid), 128'd1);
        check_eq("t5 B w0", 128'(bus.word_data), 128'h10203040);
        check_eq("t5 B level", 128'(fifo_level), 128'd1);
        bus.word_ready = 1'b1;
        repeat (5) step();
        bus.word_ready = 1'b0;
        check_eq("t5 drained", 128'(fifo_level), 128'd0);

        // Drop and clear in the same cycle: set wins.
        bus.blk_valid = 1'b1;
        bus.blk_data  = A;
        step();
        bus.blk_data = B;
        step();
        check_eq("t6 pre ovf", 128'(overflow), 128'd0);
        bus.blk_data = C;
        ovf_clr      = 1'b1;
        step();
        bus.blk_valid = 1'b0;
        ovf_clr       = 1'b0;
        check_eq("t6 ovf set", 128'(overflow), 128'd1);
        check_eq("t6 level", 128'(fifo_level), 128'd2);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_eq("t6 ovf clr", 128'(overflow), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
